// File: rtl/fsm_serial_sched_pkg.sv
// Shared types for the serial-detector scheduler: state encoding and parameter legality check.
package fsm_serial_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } sched_state_e;

  // Only a Moore (1) or Mealy (0) detector response latency is supported.
  function automatic bit z_lat_legal(input int unsigned z_lat);
    return (z_lat <= 1);
  endfunction

endpackage

// File: rtl/fsm_serial_sched_if.sv
// Requester-side bus of the scheduler: job requests/words in, grant/result out.
interface fsm_serial_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned HW = $clog2(WIDTH + 1);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] word;
  logic [NREQ-1:0]       grant;
  logic [IW-1:0]         owner;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      z_vec;
  logic [HW-1:0]         hit_cnt;

  modport master (
    output req, word,
    input  grant, owner, busy, done, z_vec, hit_cnt
  );

  modport slave (
    input  req, word,
    output grant, owner, busy, done, z_vec, hit_cnt
  );
endinterface

// File: rtl/fsm_serial_sched_rr_arbiter.sv
// Round-robin picker: combinational first-set search from the held pointer, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         grant_oh,
  output logic [$clog2(NREQ)-1:0] grant_idx
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin : pick
    int unsigned idx;
    logic        found;
    idx       = 0;
    found     = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(ptr_q) + off) % NREQ;
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = IW'((32'(grant_idx) + 1) % NREQ);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fsm_serial_sched.sv
// Shares one serial sequence detector among NREQ requesters: clear it, shift a snapshot word in
// MSB-first, collect the per-bit z response and hand the vector and popcount back to the owner.
module fsm_serial_sched
  import fsm_serial_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned Z_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  fsm_serial_sched_if.slave   bus,
  output logic                fsm_rst,
  output logic                fsm_x,
  input  logic                fsm_z
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned HW = $clog2(WIDTH + 1);

  if (!z_lat_legal(Z_LAT)) begin : g_bad_z_lat
    $error("fsm_serial_sched: Z_LAT must be 0 or 1");
  end

  sched_state_e     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] z_vec_q, z_vec_d;
  logic [HW-1:0]    hit_q, hit_d;
  logic             cap_vld_q, cap_vld_d;
  logic [CW-1:0]    cap_idx_q, cap_idx_d;

  logic [NREQ-1:0]  arb_oh;
  logic [IW-1:0]    arb_idx;
  logic             arb_adv;
  logic             cap_en;
  logic [CW-1:0]    cap_idx;
  logic [CW-1:0]    cap_bit;
  logic [CW-1:0]    x_bit;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.req),
    .advance  (arb_adv),
    .grant_oh (arb_oh),
    .grant_idx(arb_idx)
  );

  // A Moore detector answers one cycle late, so capture runs off a delayed copy of the bit index.
  always_comb begin
    cap_vld_d = (state_q == S_SHIFT);
    cap_idx_d = cnt_q;
    if (Z_LAT == 0) begin
      cap_en  = (state_q == S_SHIFT);
      cap_idx = cnt_q;
    end else begin
      cap_en  = cap_vld_q;
      cap_idx = cap_idx_q;
    end
    cap_bit = CW'(WIDTH - 1) - cap_idx;
    x_bit   = CW'(WIDTH - 1) - cnt_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    grant_d = grant_q;
    owner_d = owner_q;
    z_vec_d = z_vec_q;
    hit_d   = hit_q;
    arb_adv = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          arb_adv = 1'b1;
          grant_d = arb_oh;
          owner_d = arb_idx;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_oh[i]) begin
              snap_d = bus.word[i*WIDTH +: WIDTH];
            end
          end
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        z_vec_d = '0;
        hit_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = (Z_LAT != 0) ? S_DRAIN : S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase

    if (cap_en) begin
      z_vec_d[cap_bit] = fsm_z;
      hit_d            = hit_d + HW'(fsm_z);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      snap_q    <= '0;
      grant_q   <= '0;
      owner_q   <= '0;
      z_vec_q   <= '0;
      hit_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      z_vec_q   <= z_vec_d;
      hit_q     <= hit_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  always_comb begin
    fsm_rst = reset | (state_q == S_CLR);
    fsm_x   = 1'b0;
    if (state_q == S_SHIFT) begin
      fsm_x = snap_q[x_bit];
    end
  end

  assign bus.grant   = grant_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.z_vec   = z_vec_q;
  assign bus.hit_cnt = hit_q;

endmodule

// File: tb/tb_fsm_serial_sched.sv
// Bench for fsm_serial_sched: cycle timeline model with per-cycle compare, directed literal
// scenarios, randomized requesters, plus a Mealy (Z_LAT=0) build driven by a combinational echo.
module tb_fsm_serial_sched;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int          LAST  = WIDTH + 1 + 1;  // cycles from grant to done with Z_LAT=1

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fsm_serial_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
  fsm_serial_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus2 ();
  logic fsm_rst, fsm_x, fsm_z;
  logic fsm_rst2, fsm_x2, fsm_z2;

  fsm_serial_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .Z_LAT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .fsm_rst(fsm_rst), .fsm_x(fsm_x), .fsm_z(fsm_z)
  );

  fsm_serial_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .Z_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus2), .fsm_rst(fsm_rst2), .fsm_x(fsm_x2), .fsm_z(fsm_z2)
  );

  // Stub detectors: registered echo (Moore) and combinational echo (Mealy).
  always_ff @(posedge clk) fsm_z <= fsm_rst ? 1'b0 : fsm_x;
  assign fsm_z2 = fsm_x2 & ~fsm_rst2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] exp, input logic [31:0] act);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: a job is "t cycles since grant"; an echo detector returns the word itself.
  bit               m_active = 1'b0;
  int               m_t = 0, m_ptr = 0, m_owner = 0, m_hit = 0;
  logic [WIDTH-1:0] m_snap = '0, m_zv = '0;

  task automatic model_step();
    if (reset) begin
      m_active = 1'b0; m_t = 0; m_ptr = 0; m_owner = 0; m_zv = '0; m_hit = 0;
    end else if (m_active) begin
      m_t++;
      if (m_t == LAST) begin
        m_zv  = m_snap;
        m_hit = $countones(m_snap);
      end
      if (m_t > LAST) m_active = 1'b0;
    end else if (bus.req != '0) begin
      for (int off = 0; off < NREQ; off++) begin
        int i;
        i = (m_ptr + off) % NREQ;
        if (!m_active && bus.req[i]) begin
          m_active = 1'b1;
          m_t      = 0;
          m_owner  = i;
          m_snap   = bus.word[i*WIDTH +: WIDTH];
          m_ptr    = (i + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic model_compare();
    logic exp_x;
    exp_x = 1'b0;
    if (m_active && m_t >= 1 && m_t <= WIDTH) exp_x = m_snap[WIDTH - m_t];
    chk("busy", 32'(m_active), 32'(bus.busy));
    chk("grant", m_active ? (32'd1 << m_owner) : 32'd0, 32'(bus.grant));
    chk("owner", 32'(m_owner), 32'(bus.owner));
    chk("done", 32'(m_active && m_t == LAST), 32'(bus.done));
    chk("fsm_rst", 32'(reset || (m_active && m_t == 0)), 32'(fsm_rst));
    chk("fsm_x", 32'(exp_x), 32'(fsm_x));
    if (!m_active || m_t == LAST) begin
      chk("z_vec", 32'(m_zv), 32'(bus.z_vec));
      chk("hit_cnt", 32'(m_hit), 32'(bus.hit_cnt));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_compare();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int               r_lat, r_own, r_rst;
  logic [WIDTH-1:0] r_zv;
  logic [3:0]       r_hc;

  // Run one job on the Moore build; optionally drop req and scramble the word drop_at cycles in.
  task automatic do_job(input int idx, input logic [WIDTH-1:0] w, input int drop_at);
    bit ok;
    ok = 1'b0;
    r_lat = -1; r_own = -1; r_rst = 0; r_zv = '0; r_hc = '0;
    bus.word[idx*WIDTH +: WIDTH] = w;
    bus.req[idx] = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (bus.grant != '0) ok = 1'b1;
    end
    chk("grant_seen", 32'd1, 32'(ok));
    if (ok) begin
      r_own = int'(bus.owner);
      r_rst = int'(fsm_rst);
      for (int i = 1; i <= 60 && r_lat < 0; i++) begin
        tick();
        if (i == drop_at) begin
          bus.req[idx] = 1'b0;
          bus.word[idx*WIDTH +: WIDTH] = '0;
        end
        r_rst += int'(fsm_rst);
        if (bus.done) begin
          r_lat = i;
          r_zv  = bus.z_vec;
          r_hc  = bus.hit_cnt;
        end
      end
      chk("done_seen", 32'd1, 32'(r_lat > 0));
    end
    bus.req[idx] = 1'b0;
    tick();
    tick();
  endtask

  int               owners[5];
  logic [WIDTH-1:0] zvs[5];
  int               hits[5];
  int               nd;

  initial begin
    reset     = 1'b1;
    bus.req   = '0;
    bus.word  = '0;
    bus2.req  = '0;
    bus2.word = '0;
    repeat (3) tick();
    chk("rst_busy", 32'd0, 32'(bus.busy));
    chk("rst_grant", 32'd0, 32'(bus.grant));
    chk("rst_owner", 32'd0, 32'(bus.owner));
    chk("rst_z_vec", 32'd0, 32'(bus.z_vec));
    chk("rst_hit", 32'd0, 32'(bus.hit_cnt));
    chk("rst_fsm_x", 32'd0, 32'(fsm_x));
    chk("rst_fsm_rst", 32'd1, 32'(fsm_rst));
    reset = 1'b0;
    tick();

    // Single job
    do_job(0, 8'hA5, -1);
    chk("t1_owner", 32'd0, 32'(r_own));
    chk("t1_latency", 32'd10, 32'(r_lat));
    chk("t1_z_vec", 32'hA5, 32'(r_zv));
    chk("t1_hit", 32'd4, 32'(r_hc));

    // Round-robin with all requesters held
    reset_pulse();
    bus.word = {8'h08, 8'h04, 8'h02, 8'h01};
    bus.req  = 4'b1111;
    nd = 0;
    for (int i = 0; i < 300 && nd < 5; i++) begin
      tick();
      if (bus.done) begin
        owners[nd] = int'(bus.owner);
        zvs[nd]    = bus.z_vec;
        hits[nd]   = int'(bus.hit_cnt);
        nd++;
        if (nd == 5) bus.req = '0;
      end
    end
    bus.req = '0;
    chk("t2_jobs", 32'd5, 32'(nd));
    for (int k = 0; k < 5; k++) begin
      chk("t2_owner", 32'(k % 4), 32'(owners[k]));
      chk("t2_z_vec", 32'd1 << (k % 4), 32'(zvs[k]));
      chk("t2_hit", 32'd1, 32'(hits[k]));
    end
    repeat (LAST + 2) tick();

    // Detector cleared between jobs
    do_job(0, 8'hFF, -1);
    chk("t3a_z_vec", 32'hFF, 32'(r_zv));
    chk("t3a_hit", 32'd8, 32'(r_hc));
    do_job(0, 8'h00, -1);
    chk("t3b_z_vec", 32'h00, 32'(r_zv));
    chk("t3b_hit", 32'd0, 32'(r_hc));
    chk("t3b_rst_cycles", 32'd1, 32'(r_rst));

    // Mid-job reset in SHIFT cycle 3
    begin
      bit ok;
      ok = 1'b0;
      bus.word[2*WIDTH +: WIDTH] = 8'hF0;
      bus.req[2] = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
        tick();
        if (bus.grant != '0) ok = 1'b1;
      end
      chk("t4_grant_seen", 32'd1, 32'(ok));
      repeat (4) tick();
      reset   = 1'b1;
      bus.req = '0;
      tick();
      chk("t4_busy", 32'd0, 32'(bus.busy));
      chk("t4_grant", 32'd0, 32'(bus.grant));
      chk("t4_z_vec", 32'd0, 32'(bus.z_vec));
      reset = 1'b0;
      nd = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        nd += int'(bus.done);
      end
      chk("t4_no_done", 32'd0, 32'(nd));
      do_job(2, 8'hF0, -1);
      chk("t4_z_vec_retry", 32'hF0, 32'(r_zv));
      chk("t4_hit_retry", 32'd4, 32'(r_hc));
    end

    // Owner drops req and changes its word mid-SHIFT
    do_job(1, 8'h3C, 3);
    chk("t5_latency", 32'd10, 32'(r_lat));
    chk("t5_z_vec", 32'h3C, 32'(r_zv));
    chk("t5_hit", 32'd4, 32'(r_hc));

    // Mealy build: done at T+WIDTH+1
    begin
      bit ok;
      int lat;
      ok = 1'b0;
      lat = -1;
      bus2.word[0 +: WIDTH] = 8'h81;
      bus2.req[0] = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
        tick();
        if (bus2.grant != '0) ok = 1'b1;
      end
      chk("t6_grant_seen", 32'd1, 32'(ok));
      chk("t6_grant", 32'h1, 32'(bus2.grant));
      for (int i = 1; i <= 40 && lat < 0; i++) begin
        tick();
        if (bus2.done) begin
          lat = i;
          chk("t6_z_vec", 32'h81, 32'(bus2.z_vec));
          chk("t6_hit", 32'd2, 32'(bus2.hit_cnt));
        end
      end
      chk("t6_latency", 32'(WIDTH + 1), 32'(lat));
      bus2.req = '0;
    end

    // Randomized requesters against the model
    for (int c = 0; c < 2500; c++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if (m_active && m_t == LAST) begin
        bus.req[m_owner] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i] && $urandom_range(0, 7) == 0) begin
          bus.word[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          bus.req[i] = 1'b1;
        end
      end
    end

    reset   = 1'b0;
    bus.req = '0;
    repeat (LAST + 4) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
